// File: rtl/run_trace_controller.sv
// -----------------------------------------------------------------------------
// run_trace_controller
//
// Run-control and output-trace engine placed between the CPU top and a debug
// or test host. The host commands a HALT, a single STEP, a run of N cycles or
// a free run. The block drives the CPU clock-enable to match. While the CPU is
// enabled, every change on the CPU output bus is timestamped with the enabled
// cycle count and queued in a show-ahead trace FIFO.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   cmd_valid/ready     host command handshake (HALT is always accepted)
//   cmd_op, cmd_count   command opcode and RUN_N cycle budget
//   cpu_enable          registered clock-enable to the CPU
//   running             high whenever the controller is not idle
//   cycle_count         enabled cycles since reset (wraps)
//   output_peripherals  CPU output bus under observation
//   trace_valid/ready   FIFO head valid / consumer pop
//   trace_data          {timestamp, value} at the FIFO head
//   trace_overflow      sticky: a change was dropped on a full FIFO
//   done                one-cycle pulse when STEP or RUN_N completes
// -----------------------------------------------------------------------------
module run_trace_controller #(
  parameter int CYCLE_WIDTH = 32,
  parameter int OUT_WIDTH   = 4,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [CYCLE_WIDTH-1:0]         cmd_count,
  output logic                           cpu_enable,
  output logic                           running,
  output logic [CYCLE_WIDTH-1:0]         cycle_count,
  input  logic [OUT_WIDTH-1:0]           output_peripherals,
  output logic                           trace_valid,
  input  logic                           trace_ready,
  output logic [CYCLE_WIDTH+OUT_WIDTH-1:0] trace_data,
  output logic                           trace_overflow,
  output logic                           done
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int DW = CYCLE_WIDTH + OUT_WIDTH;

  localparam logic [1:0] OP_HALT     = 2'b00;
  localparam logic [1:0] OP_STEP     = 2'b01;
  localparam logic [1:0] OP_RUN_N    = 2'b10;
  localparam logic [1:0] OP_RUN_FREE = 2'b11;

  localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
  localparam logic [CYCLE_WIDTH-1:0] CNT_ONE = CYCLE_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_RUN_N,
    S_RUN_FREE
  } state_t;

  state_t                 state;
  logic [CYCLE_WIDTH-1:0] remaining;
  logic [OUT_WIDTH-1:0]   last;
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [DW-1:0]          mem [TRACE_DEPTH];

  logic accept;
  logic fifo_empty;
  logic fifo_full;
  logic capture;
  logic do_pop;
  logic do_push;

  // HALT bypasses the busy states so a run can always be stopped.
  assign cmd_ready = (state == S_IDLE) || (state == S_RUN_FREE) || (cmd_op == OP_HALT);
  assign accept    = cmd_valid && cmd_ready;
  assign running   = (state != S_IDLE);

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign capture = cpu_enable && (output_peripherals != last);
  assign do_pop  = !fifo_empty && trace_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_push = capture && (!fifo_full || do_pop);

  assign trace_valid = !fifo_empty;
  assign trace_data  = mem[rd_ptr[AW-1:0]];

  // Run-control FSM; cpu_enable and done are registered with the state.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cpu_enable <= 1'b0;
      done       <= 1'b0;
      remaining  <= '0;
    end else begin
      done <= 1'b0;
      if (accept && cmd_op == OP_HALT) begin
        state      <= S_IDLE;
        cpu_enable <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              case (cmd_op)
                OP_STEP: begin
                  state      <= S_STEP;
                  cpu_enable <= 1'b1;
                end
                OP_RUN_N: begin
                  if (cmd_count != '0) begin
                    state      <= S_RUN_N;
                    remaining  <= cmd_count;
                    cpu_enable <= 1'b1;
                  end else begin
                    done <= 1'b1;
                  end
                end
                OP_RUN_FREE: begin
                  state      <= S_RUN_FREE;
                  cpu_enable <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          S_STEP: begin
            state      <= S_IDLE;
            cpu_enable <= 1'b0;
            done       <= 1'b1;
          end
          S_RUN_N: begin
            if (remaining == CNT_ONE) begin
              state      <= S_IDLE;
              cpu_enable <= 1'b0;
              done       <= 1'b1;
            end else begin
              remaining <= remaining - CNT_ONE;
            end
          end
          S_RUN_FREE: ;
          default: begin
            state      <= S_IDLE;
            cpu_enable <= 1'b0;
          end
        endcase
      end
    end
  end

  // Cycle counter, change detector and FIFO control.
  always_ff @(posedge clock) begin
    // Tracking the bus every cycle means changes made while halted are
    // absorbed silently; it also loads the reference value during reset.
    last <= output_peripherals;
    if (reset) begin
      cycle_count    <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (cpu_enable) cycle_count <= cycle_count + CNT_ONE;
      if (do_push)    wr_ptr      <= wr_ptr + PTR_ONE;
      if (do_pop)     rd_ptr      <= rd_ptr + PTR_ONE;
      if (capture && !do_push) trace_overflow <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; resetting the pointers
  // already marks it empty, and a reset-free array can map onto RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= {cycle_count, output_peripherals};
  end

endmodule

// File: tb/tb_run_trace_controller.sv
// -----------------------------------------------------------------------------
// tb_run_trace_controller
//
// Directed bench for run_trace_controller (16-bit counter, 4-bit bus, 4-deep
// FIFO). Expected trace entries are pushed into a scoreboard queue as the
// stimulus creates them; a monitor pops and compares whenever the DUT hands
// an entry to the consumer. Enabled cycles and done pulses are tallied by the
// monitor and compared against hand-computed totals.
// -----------------------------------------------------------------------------
module tb_run_trace_controller;

  localparam int CW = 16;
  localparam int OW = 4;
  localparam int TD = 4;

  localparam logic [1:0] OP_HALT     = 2'b00;
  localparam logic [1:0] OP_STEP     = 2'b01;
  localparam logic [1:0] OP_RUN_N    = 2'b10;
  localparam logic [1:0] OP_RUN_FREE = 2'b11;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [CW-1:0]     cmd_count;
  logic              cpu_enable;
  logic              running;
  logic [CW-1:0]     cycle_count;
  logic [OW-1:0]     output_peripherals;
  logic              trace_valid;
  logic              trace_ready;
  logic [CW+OW-1:0]  trace_data;
  logic              trace_overflow;
  logic              done;

  int tests = 0;
  int fails = 0;
  int en_total = 0;
  int done_total = 0;
  int en_base;
  int done_base;
  logic [CW+OW-1:0] sb [$];

  run_trace_controller #(
    .CYCLE_WIDTH(CW),
    .OUT_WIDTH  (OW),
    .TRACE_DEPTH(TD)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_op            (cmd_op),
    .cmd_count         (cmd_count),
    .cpu_enable        (cpu_enable),
    .running           (running),
    .cycle_count       (cycle_count),
    .output_peripherals(output_peripherals),
    .trace_valid       (trace_valid),
    .trace_ready       (trace_ready),
    .trace_data        (trace_data),
    .trace_overflow    (trace_overflow),
    .done              (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: tallies and scoreboard compare, sampled on the falling edge.
  always @(negedge clock) begin
    if (cpu_enable === 1'b1) en_total++;
    if (done === 1'b1) done_total++;
    if (reset === 1'b0 && trace_valid === 1'b1 && trace_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL trace_unexpected: got %0h, expected no entry", trace_data);
      end else begin
        check("trace_entry", 64'(trace_data), 64'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mark();
    en_base   = en_total;
    done_base = done_total;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    trace_ready = 1'b0;
    sb.delete();
    tick();
    tick();
    reset = 1'b0;
    mark();
  endtask

  // Drive one command; it is accepted on the next rising edge.
  task automatic send(input logic [1:0] op, input logic [CW-1:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    #0;
    check("cmd_ready_at_issue", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_op = OP_HALT;
    cmd_count = '0;
    output_peripherals = 4'h0;
    do_reset();

    // Reset state
    check("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_cycle_count", 64'(cycle_count), 64'd0);
    check("rst_trace_valid", 64'(trace_valid), 64'd0);
    check("rst_overflow", 64'(trace_overflow), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // RUN_N 5
    send(OP_RUN_N, 16'd5);
    check("run5_enable_first", 64'(cpu_enable), 64'd1);
    check("run5_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    repeat (6) tick();
    check("run5_enabled_cycles", 64'(en_total - en_base), 64'd5);
    check("run5_done_pulses", 64'(done_total - done_base), 64'd1);
    check("run5_cycle_count", 64'(cycle_count), 64'd5);
    check("run5_running_after", 64'(running), 64'd0);

    // Two STEPs
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send(OP_STEP, '0);
      check("step_enable", 64'(cpu_enable), 64'd1);
      tick();
      check("step_enable_off", 64'(cpu_enable), 64'd0);
      check("step_done", 64'(done), 64'd1);
      tick();
    end
    check("step_enabled_cycles", 64'(en_total - en_base), 64'd2);
    check("step_done_pulses", 64'(done_total - done_base), 64'd2);
    check("step_cycle_count", 64'(cycle_count), 64'd2);

    // RUN_FREE, ignored RUN_N, HALT after 20 enabled cycles
    do_reset();
    send(OP_RUN_FREE, '0);
    repeat (9) tick();
    send(OP_RUN_N, 16'd3);
    check("free_running_after_runn", 64'(running), 64'd1);
    repeat (9) tick();
    send(OP_HALT, '0);
    check("halt_running", 64'(running), 64'd0);
    check("halt_cpu_enable", 64'(cpu_enable), 64'd0);
    repeat (5) tick();
    check("free_cycle_count", 64'(cycle_count), 64'd20);
    check("free_enabled_cycles", 64'(en_total - en_base), 64'd20);
    check("free_no_done", 64'(done_total - done_base), 64'd0);

    // Trace capture during RUN_N 3; change in IDLE is not traced
    do_reset();
    trace_ready = 1'b1;
    send(OP_RUN_N, 16'd3);
    tick();
    output_peripherals = 4'hA;          // seen during the enabled cycle with count 1
    sb.push_back({16'd1, 4'hA});
    repeat (4) tick();
    output_peripherals = 4'h5;          // idle: absorbed, not traced
    repeat (4) tick();
    check("cap_sb_drained", 64'(sb.size()), 64'd0);
    check("cap_trace_valid", 64'(trace_valid), 64'd0);
    check("cap_cycle_count", 64'(cycle_count), 64'd3);

    // Overflow with 6 changes into a 4-deep FIFO, then push+pop while full
    output_peripherals = 4'h0;
    do_reset();
    send(OP_RUN_FREE, '0);
    for (int i = 1; i <= 6; i++) begin
      output_peripherals = 4'(i);       // captured with timestamp i-1
      if (i <= 4) sb.push_back({16'(i - 1), 4'(i)});
      tick();
    end
    check("ovf_flag", 64'(trace_overflow), 64'd1);
    check("ovf_head_valid", 64'(trace_valid), 64'd1);
    output_peripherals = 4'h7;          // push at timestamp 6 with a pop while full
    trace_ready = 1'b1;
    sb.push_back({16'd6, 4'h7});
    tick();
    trace_ready = 1'b0;
    send(OP_HALT, '0);
    trace_ready = 1'b1;
    repeat (6) tick();
    check("ovf_sb_drained", 64'(sb.size()), 64'd0);
    check("ovf_fifo_empty", 64'(trace_valid), 64'd0);
    check("ovf_flag_sticky", 64'(trace_overflow), 64'd1);

    // RUN_N 0: done pulse, no enabled cycles
    do_reset();
    send(OP_RUN_N, 16'd0);
    check("run0_done", 64'(done), 64'd1);
    check("run0_running", 64'(running), 64'd0);
    tick();
    check("run0_done_pulses", 64'(done_total - done_base), 64'd1);
    check("run0_enabled_cycles", 64'(en_total - en_base), 64'd0);

    // Reset mid-RUN_N discards the FIFO
    send(OP_RUN_N, 16'd10);
    output_peripherals = 4'h3;
    tick();
    check("midrst_entry_present", 64'(trace_valid), 64'd1);
    reset = 1'b1;
    tick();
    check("midrst_running", 64'(running), 64'd0);
    check("midrst_cpu_enable", 64'(cpu_enable), 64'd0);
    check("midrst_fifo_empty", 64'(trace_valid), 64'd0);
    check("midrst_cycle_count", 64'(cycle_count), 64'd0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
